// File: rtl/seq_enable_bank.sv
// seq_enable_bank: multi-lane enabled register bank with load tracking.
// Per-lane qualified load, written flag, update pulse, saturating counter.
module seq_enable_bank #(
    parameter int               WIDTH   = 8,
    parameter int               NUM_CH  = 4,
    parameter int               EN_MODE = 0,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter int               CNT_W   = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clr,
    input  logic [NUM_CH-1:0]         en_a,
    input  logic [NUM_CH-1:0]         en_b,
    input  logic [NUM_CH*WIDTH-1:0]   d,
    output logic [NUM_CH*WIDTH-1:0]   q,
    output logic [NUM_CH-1:0]         vld,
    output logic [NUM_CH-1:0]         upd,
    output logic [NUM_CH*CNT_W-1:0]   cnt,
    output logic [NUM_CH-1:0]         sat,
    output logic                      any_upd
);

    if (EN_MODE < 0 || EN_MODE > 2) begin : g_bad_mode
        $error("seq_enable_bank: EN_MODE must be 0, 1 or 2");
    end

    typedef enum logic {
        EMPTY  = 1'b0,
        LOADED = 1'b1
    } lane_st_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    lane_st_t          r_st     [NUM_CH];
    lane_st_t          w_st_nxt [NUM_CH];
    logic [WIDTH-1:0]  r_q      [NUM_CH];
    logic [CNT_W-1:0]  r_cnt    [NUM_CH];
    logic [NUM_CH-1:0] r_upd;
    logic [NUM_CH-1:0] r_sat;
    logic [NUM_CH-1:0] w_ld;

    // Combine the two enables of each lane into its load strobe
    always_comb begin
        w_ld = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            case (EN_MODE)
                0:       w_ld[i] = en_a[i] & en_b[i];
                1:       w_ld[i] = en_a[i] | en_b[i];
                default: w_ld[i] = en_a[i] ^ en_b[i];
            endcase
        end
    end

    // Lane written-flag state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_st[i] <= EMPTY;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_st[i] <= w_st_nxt[i];
            end
        end
    end

    // Lane next state: clear empties, load fills, otherwise hold
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            w_st_nxt[i] = r_st[i];
            if (clr) begin
                w_st_nxt[i] = EMPTY;
            end else if (w_ld[i]) begin
                w_st_nxt[i] = LOADED;
            end
        end
    end

    // Lane data, update pulse and saturating load counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_upd <= '0;
            r_sat <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_q[i]   <= RST_VAL;
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (clr) begin
                    r_q[i]   <= RST_VAL;
                    r_cnt[i] <= '0;
                    r_upd[i] <= 1'b0;
                    r_sat[i] <= 1'b0;
                end else if (w_ld[i]) begin
                    r_q[i]   <= d[i*WIDTH +: WIDTH];
                    r_upd[i] <= 1'b1;
                    if (r_cnt[i] != CNT_MAX) begin
                        r_cnt[i] <= r_cnt[i] + CNT_ONE;
                    end else begin
                        r_sat[i] <= 1'b1;
                    end
                end else begin
                    r_upd[i] <= 1'b0;
                end
            end
        end
    end

    // Flatten lane registers onto the output buses
    always_comb begin
        q   = '0;
        cnt = '0;
        vld = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            q[i*WIDTH +: WIDTH]   = r_q[i];
            cnt[i*CNT_W +: CNT_W] = r_cnt[i];
            vld[i]                = (r_st[i] == LOADED);
        end
    end

    assign upd     = r_upd;
    assign sat     = r_sat;
    assign any_upd = |r_upd;

endmodule

// File: tb/tb_seq_enable_bank.sv
// tb_seq_enable_bank: directed scoreboard bench over AND/OR/XOR instances.
// AND instance uses a 2-bit counter to reach saturation quickly.
module tb_seq_enable_bank;

    localparam int W = 8;
    localparam int N = 4;

    logic           clk;
    logic           rst_n;
    logic           clr;
    logic [N-1:0]   en_a;
    logic [N-1:0]   en_b;
    logic [N*W-1:0] d;

    logic [N*W-1:0] q_o   [3];
    logic [N-1:0]   vld_o [3];
    logic [N-1:0]   upd_o [3];
    logic [N-1:0]   sat_o [3];
    logic           any_o [3];
    logic [N*2-1:0] cnt_a;
    logic [N*4-1:0] cnt_o;
    logic [N*4-1:0] cnt_x;

    int checks = 0;
    int errors = 0;

    seq_enable_bank #(.WIDTH(W), .NUM_CH(N), .EN_MODE(0),
                      .RST_VAL(8'h00), .CNT_W(2)) u_and (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .en_a(en_a), .en_b(en_b), .d(d),
        .q(q_o[0]), .vld(vld_o[0]), .upd(upd_o[0]),
        .cnt(cnt_a), .sat(sat_o[0]), .any_upd(any_o[0])
    );

    seq_enable_bank #(.WIDTH(W), .NUM_CH(N), .EN_MODE(1),
                      .RST_VAL(8'h00), .CNT_W(4)) u_or (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .en_a(en_a), .en_b(en_b), .d(d),
        .q(q_o[1]), .vld(vld_o[1]), .upd(upd_o[1]),
        .cnt(cnt_o), .sat(sat_o[1]), .any_upd(any_o[1])
    );

    seq_enable_bank #(.WIDTH(W), .NUM_CH(N), .EN_MODE(2),
                      .RST_VAL(8'h00), .CNT_W(4)) u_xor (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .en_a(en_a), .en_b(en_b), .d(d),
        .q(q_o[2]), .vld(vld_o[2]), .upd(upd_o[2]),
        .cnt(cnt_x), .sat(sat_o[2]), .any_upd(any_o[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state per instance and lane
    logic [7:0] mq   [3][N];
    logic       mvld [3][N];
    logic       mupd [3][N];
    logic       msat [3][N];
    int         mcnt [3][N];

    typedef struct packed {
        logic [1:0]     m;
        logic [N*W-1:0] q;
        logic [N-1:0]   v;
        logic [N-1:0]   u;
        logic [N-1:0]   s;
        logic [N*4-1:0] c;
    } exp_t;

    exp_t sbq[$];

    function automatic logic ld_of(input int m, input logic a, input logic b);
        case (m)
            0:       return a & b;
            1:       return a | b;
            default: return a ^ b;
        endcase
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 3; m++) begin
            for (int i = 0; i < N; i++) begin
                mq[m][i]   = 8'h00;
                mvld[m][i] = 1'b0;
                mupd[m][i] = 1'b0;
                msat[m][i] = 1'b0;
                mcnt[m][i] = 0;
            end
        end
    endtask

    task automatic model_edge(input logic c, input logic [N-1:0] a,
                              input logic [N-1:0] b, input logic [N*W-1:0] dv);
        int mx;
        for (int m = 0; m < 3; m++) begin
            mx = (m == 0) ? 3 : 15;
            for (int i = 0; i < N; i++) begin
                if (c) begin
                    mq[m][i]   = 8'h00;
                    mvld[m][i] = 1'b0;
                    mupd[m][i] = 1'b0;
                    msat[m][i] = 1'b0;
                    mcnt[m][i] = 0;
                end else if (ld_of(m, a[i], b[i])) begin
                    mq[m][i]   = dv[i*W +: W];
                    mvld[m][i] = 1'b1;
                    mupd[m][i] = 1'b1;
                    if (mcnt[m][i] < mx) mcnt[m][i] = mcnt[m][i] + 1;
                    else msat[m][i] = 1'b1;
                end else begin
                    mupd[m][i] = 1'b0;
                end
            end
        end
    endtask

    task automatic push_all();
        exp_t e;
        for (int m = 0; m < 3; m++) begin
            e = '0;
            e.m = 2'(m);
            for (int i = 0; i < N; i++) begin
                e.q[i*W +: W] = mq[m][i];
                e.v[i] = mvld[m][i];
                e.u[i] = mupd[m][i];
                e.s[i] = msat[m][i];
                e.c[i*4 +: 4] = 4'(mcnt[m][i]);
            end
            sbq.push_back(e);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [N*4-1:0] cnt_of(input int m);
        logic [N*4-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            case (m)
                0:       r[i*4 +: 4] = {2'b00, cnt_a[i*2 +: 2]};
                1:       r[i*4 +: 4] = cnt_o[i*4 +: 4];
                default: r[i*4 +: 4] = cnt_x[i*4 +: 4];
            endcase
        end
        return r;
    endfunction

    task automatic pop_check(input string tag);
        exp_t e;
        int   m;
        repeat (3) begin
            checks++;
            assert (sbq.size() > 0) else begin
                errors++;
                $error("FAIL %s sb_empty: observed 0 expected 3", tag);
            end
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                m = int'(e.m);
                chk($sformatf("%s m%0d q", tag, m), q_o[m], e.q);
                chk($sformatf("%s m%0d vld", tag, m), 32'(vld_o[m]), 32'(e.v));
                chk($sformatf("%s m%0d upd", tag, m), 32'(upd_o[m]), 32'(e.u));
                chk($sformatf("%s m%0d sat", tag, m), 32'(sat_o[m]), 32'(e.s));
                chk($sformatf("%s m%0d cnt", tag, m), 32'(cnt_of(m)), 32'(e.c));
                chk($sformatf("%s m%0d any", tag, m), 32'(any_o[m]), 32'(|e.u));
            end
        end
    endtask

    task automatic step(input string tag, input logic c,
                        input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [N*W-1:0] dv);
        clr  = c;
        en_a = a;
        en_b = b;
        d    = dv;
        model_edge(c, a, b, dv);
        push_all();
        @(posedge clk);
        #1;
        pop_check(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        clr   = 1'b0;
        en_a  = '0;
        en_b  = '0;
        d     = '0;
        model_reset();
        #2;
        push_all();
        pop_check("reset0");
        @(negedge clk);
        rst_n = 1'b1;

        step("and_a_only", 1'b0, 4'b0001, 4'b0000, 32'h0000_00A5);
        chk("and_hold_q0", 32'(q_o[0][7:0]), 32'h00);
        chk("and_hold_upd0", 32'(upd_o[0][0]), 32'h0);
        step("and_ab", 1'b0, 4'b0001, 4'b0001, 32'h0000_00A5);
        chk("and_load_q0", 32'(q_o[0][7:0]), 32'hA5);
        chk("and_load_cnt0", 32'(cnt_a[1:0]), 32'h1);
        chk("and_load_upd0", 32'(upd_o[0][0]), 32'h1);
        step("and_idle", 1'b0, 4'b0000, 4'b0000, 32'h0000_00A5);
        chk("and_upd0_fall", 32'(upd_o[0][0]), 32'h0);

        for (int k = 0; k < 4; k++) begin
            logic [1:0] ab;
            ab = 2'(k);
            step($sformatf("tt_%0d", k), 1'b0, {ab[1], 3'b000},
                 {ab[0], 3'b000}, 32'h3C00_0000);
        end
        chk("tt_and_cnt3", 32'(cnt_a[7:6]), 32'h1);
        chk("tt_or_cnt3", 32'(cnt_o[15:12]), 32'h3);
        chk("tt_xor_cnt3", 32'(cnt_x[15:12]), 32'h2);
        chk("tt_xor_q3", 32'(q_o[2][31:24]), 32'h3C);

        for (int k = 1; k <= 5; k++) begin
            step($sformatf("sat_%0d", k), 1'b0, 4'b0100, 4'b0100,
                 32'(k) << 16);
            chk($sformatf("sat_upd2_%0d", k), 32'(upd_o[0][2]), 32'h1);
            if (k == 3) chk("sat_pre", 32'(sat_o[0][2]), 32'h0);
            if (k == 4) chk("sat_set", 32'(sat_o[0][2]), 32'h1);
        end
        chk("sat_q2", 32'(q_o[0][23:16]), 32'h05);
        chk("sat_cnt2", 32'(cnt_a[5:4]), 32'h3);

        step("l1_a", 1'b0, 4'b0010, 4'b0010, 32'h0000_1000);
        step("l1_b", 1'b0, 4'b0010, 4'b0010, 32'h0000_2000);
        chk("l1_cnt", 32'(cnt_a[3:2]), 32'h2);
        step("clr_ld", 1'b1, 4'b0010, 4'b0010, 32'h0000_FF00);
        chk("clr_q1", 32'(q_o[0][15:8]), 32'h00);
        chk("clr_cnt1", 32'(cnt_a[3:2]), 32'h0);
        chk("clr_vld", 32'(vld_o[0]), 32'h0);

        step("ind_ld", 1'b0, 4'b1001, 4'b1001, 32'h2200_0011);
        chk("ind_q", q_o[0], 32'h2200_0011);
        chk("ind_any", 32'(any_o[0]), 32'h1);
        step("ind_idle", 1'b0, 4'b0000, 4'b0000, 32'h2200_0011);
        chk("ind_any_fall", 32'(any_o[0]), 32'h0);

        step("pre_rst", 1'b0, 4'b1111, 4'b1111, 32'h4433_2211);
        #2;
        rst_n = 1'b0;
        model_reset();
        push_all();
        #1;
        pop_check("async_rst");
        chk("async_q", q_o[1], 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst", 1'b0, 4'b0001, 4'b0001, 32'h0000_0077);
        chk("post_rst_q0", 32'(q_o[0][7:0]), 32'h77);
        step("final", 1'b0, 4'b0000, 4'b0000, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
